// File: rtl/register_file.sv
// Operand store: 32 x 32-bit flop-based register file, two async read ports, one sync write port.
// Latency: reads are combinational (0 cycles); a write becomes visible on the edge it is sampled.
// Backpressure: none; a write is accepted on every edge with write=1, and reset wins over write.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa,
    input  logic              write,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // No write-to-read bypass: reads see storage, so a same-cycle write shows up after the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[wa] <= wdata;
        end
    end

    assign rdata1 = regs[ra1];
    assign rdata2 = regs[ra2];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a reference array predicts reads, expectations go through a queue.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra1    (ra1),
        .ra2    (ra2),
        .wa     (wa),
        .write  (write),
        .wdata  (wdata),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Rising edge; the model applies what was driven at that edge, then sampling is offset by 1ns.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (write) begin
            model[wa] = wdata;
        end
        #1;
    endtask

    // Drive read addresses, push predictions, then pop and compare after settling.
    task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        ra1 = a1;
        ra2 = a2;
        exp_q.push_back(model[a1]);
        exp_q.push_back(model[a2]);
        #1;
        chk({tag, "_rd1"}, rdata1, exp_q.pop_front());
        chk({tag, "_rd2"}, rdata2, exp_q.pop_front());
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1;
        wa    = a;
        wdata = d;
        step();
        write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;
        rst_n = 1'b0;
        write = 1'b0;
        wa    = '0;
        wdata = '0;
        ra1   = '0;
        ra2   = '0;

        // Reset, then every address on both ports reads zero.
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd(5'(i), 5'(31 - i), "reset_sweep");
        end

        // Back-to-back writes, read with no extra clock.
        wr(5'd15, 32'h0014_5601);
        wr(5'd16, 32'h0000_0987);
        rd(5'd15, 5'd16, "write_read");
        chk("write_read_abs15", rdata1, 32'h0014_5601);
        chk("write_read_abs16", rdata2, 32'h0000_0987);

        // write=0 must leave storage alone.
        @(negedge clk);
        write = 1'b0;
        wa    = 5'd15;
        wdata = 32'hDEAD_BEEF;
        step();
        rd(5'd15, 5'd16, "write_disable");
        chk("write_disable_abs", rdata1, 32'h0014_5601);

        // Read-during-write: old value before the edge, new value right after.
        @(negedge clk);
        write = 1'b1;
        wa    = 5'd21;
        wdata = 32'h0000_0987;
        rd(5'd21, 5'd21, "rdw_before");
        chk("rdw_before_abs", rdata1, 32'h0000_0000);
        step();
        write = 1'b0;
        rd(5'd21, 5'd15, "rdw_after");
        chk("rdw_after_abs", rdata1, 32'h0000_0987);

        // Both ports on one register.
        @(negedge clk);
        rd(5'd16, 5'd16, "same_addr");
        chk("same_addr_abs", rdata2, 32'h0000_0987);

        // Register 0 is writable.
        wr(5'd0, 32'h1234_5678);
        rd(5'd0, 5'd21, "reg0");
        chk("reg0_abs", rdata1, 32'h1234_5678);

        // Only the values present at the edge count.
        @(negedge clk);
        write = 1'b1;
        wa    = 5'd7;
        wdata = 32'hAAAA_0007;
        #2;
        wa    = 5'd8;
        wdata = 32'hBBBB_0008;
        step();
        write = 1'b0;
        rd(5'd7, 5'd8, "edge_sample");
        chk("edge_sample_abs8", rdata2, 32'hBBBB_0008);

        // Repeated write to one address keeps the last value.
        wr(5'd31, 32'h1111_1111);
        wr(5'd31, 32'h2222_2222);
        rd(5'd31, 5'd30, "overwrite");
        chk("overwrite_abs", rdata1, 32'h2222_2222);

        // Reset beats a simultaneous write and wipes earlier contents.
        @(negedge clk);
        rst_n = 1'b0;
        write = 1'b1;
        wa    = 5'd5;
        wdata = 32'hFFFF_FFFF;
        step();
        rst_n = 1'b1;
        write = 1'b0;
        rd(5'd5, 5'd15, "reset_prio");
        chk("reset_prio_abs5", rdata1, 32'h0000_0000);
        chk("reset_prio_abs15", rdata2, 32'h0000_0000);
        rd(5'd16, 5'd0, "reset_prio2");
        chk("reset_prio_abs16", rdata1, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
